bcd_seq_display: RTL and testbench
==================================

# bcd_seq_display

Sequential, parametrised binary-to-BCD converter with seven-segment output stage. It accepts a WIDTH-bit unsigned value on a start strobe and runs an iterative shift-add-3 (double dabble) conversion, one bit per clock. It drives DIGITS active-low seven-segment digit codes with optional leading-zero blanking and an overflow indication. It replaces the combinational divide/modulo converter in front of the display encoders for wide operands, and keeps using the existing 4-bit SSD encoder (values >9 render 'E').

## Interface
- WIDTH, 8, bit width of the binary input; must be ≥1.
- DIGITS, 3, number of BCD digits and display digits; must be ≥1.
- BLANK_LEADING, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  WIDTH  unsigned binary operand; captured on the accepting edge.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; results valid and updated in the same cycle.
- overflow  out  1  registered; 1 if the last value ≥ 10^DIGITS.
- bcd  out  4*DIGITS  registered packed BCD result; digit i is at bits [4i+3:4i]; digit 0 is units.
- seg  out  7*DIGITS  registered segment codes; digit i is at bits [7i+6:7i], ordered {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT when start=1. The edge loads bin into the shift register, clears the BCD scratch register and the overflow flag, and loads the bit counter with WIDTH.
  - SHIFT: on each edge, every scratch digit ≥5 gets +3, then {scratch, shift reg} shift left by 1 and the counter decrements. After the WIDTH-th shift the FSM goes to DONE.
  - DONE → IDLE unconditionally after 1 cycle.
- start in SHIFT or DONE is ignored (not queued). bin changes after acceptance have no effect.
- Overflow: set sticky if any 1 is shifted out of the top scratch digit during the conversion.
  - On overflow, bcd holds the value mod 10^DIGITS.
  - On overflow, every seg digit shows 'E' (0000110), overriding blanking.
- Segment codes: produced by feeding each final digit through the existing 4-bit SSD encoder, then applying blanking.
- Blanking: with BLANK_LEADING=1 and no overflow, digit i>0 is forced to 1111111 if digits i..DIGITS-1 are all zero.
- bcd, seg and overflow load only on the edge entering DONE, and hold until the next completed conversion.
- Counter width: $clog2(WIDTH+1). There is no arithmetic beyond the per-digit 4-bit +3.

## Timing
- Reset values:
  - state = IDLE; busy = 0; done = 0; overflow = 0; bcd = 0.
  - seg: digit 0 = 1000000 ('0'). Other digits = 1111111 if BLANK_LEADING, else 1000000.
- Reset has priority over everything. Reset asserted mid-conversion aborts it and restores the reset values on the next edge; no done pulse is produced.
- Start sampled at edge E0:
  - busy = 1 after E0 through edge E0+WIDTH.
  - Edge E0+WIDTH enters DONE: done = 1 and new outputs are visible for one cycle, with busy = 0.
  - Edge E0+WIDTH+1 returns to IDLE.
- Latency is WIDTH+1 edges from the start edge to the end of the done pulse. Minimum start-to-start spacing is WIDTH+2 cycles.
- A start held high continuously re-triggers on the first IDLE cycle after each DONE.
- bin = 0 is a valid conversion of full WIDTH cycles.

## Test plan
- Defaults (8/3/1), reset then bin=255 with start for 1 cycle:
  - done exactly 8 edges after the start edge.
  - bcd = 0x255, overflow = 0.
  - seg = {0100100, 0010010, 0010010}.
- Defaults, bin=7:
  - bcd = 0x007.
  - seg = {1111111, 1111111, 1111000}.
  - Repeat with BLANK_LEADING=0: seg = {1000000, 1000000, 1111000}.
- WIDTH=10, DIGITS=3, bin=1000:
  - overflow = 1, bcd = 0x000.
  - All three digits = 0000110.
  - A following bin=999 clears overflow and gives bcd = 0x999.
- Defaults, start bin=200; pulse start with bin=50 at cycle 3 of SHIFT:
  - Only one done pulse, with bcd = 0x200.
  - busy stays high 8 cycles.
- Defaults, start bin=255; assert reset at SHIFT cycle 4:
  - Next cycle: busy = 0, bcd = 0, seg = reset pattern, no done.
  - A new start with bin=100 then yields bcd = 0x100.
- Random WIDTH=16, DIGITS=5, 1000 values, back-to-back start:
  - bcd equals the decimal of bin each time.
  - One done per 18 cycles.

Source files
------------

// File: rtl/bcd_seq_display.sv
// Iterative binary-to-BCD converter (double dabble, one bit per clock) feeding
// active-low seven-segment codes with optional leading-zero blanking.
module bcd_seq_display #(
    parameter int WIDTH         = 8,
    parameter int DIGITS        = 3,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [SW-1:0]     seg_q, seg_d;
    logic              ovf_q, ovf_d;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     scr_shift;
    logic              shout;

    // Existing 4-bit SSD encoder, {g,f,e,d,c,b,a} active-low; >9 renders 'E'.
    function automatic logic [6:0] ssd(input logic [3:0] d);
        case (d)
            4'd0:    ssd = 7'b1000000;
            4'd1:    ssd = 7'b1111001;
            4'd2:    ssd = 7'b0100100;
            4'd3:    ssd = 7'b0110000;
            4'd4:    ssd = 7'b0011001;
            4'd5:    ssd = 7'b0010010;
            4'd6:    ssd = 7'b0000010;
            4'd7:    ssd = 7'b1111000;
            4'd8:    ssd = 7'b0000000;
            4'd9:    ssd = 7'b0010000;
            default: ssd = 7'b0000110;
        endcase
    endfunction

    function automatic logic [SW-1:0] seg_of(input logic [BW-1:0] b, input logic ov);
        logic [SW-1:0] s;
        logic          zero_above;
        s          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (b[4*i +: 4] == 4'd0);
            if (ov)
                s[7*i +: 7] = 7'b0000110;
            else if (BLANK_LEADING != 0 && i > 0 && zero_above)
                s[7*i +: 7] = 7'b1111111;
            else
                s[7*i +: 7] = ssd(b[4*i +: 4]);
        end
        return s;
    endfunction

    // Add-3 correction on every digit >=5, then one shift of {scratch, operand}.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
        scr_shift = {adj[BW-2:0], sh_q[WIDTH-1]};
        shout     = adj[BW-1];
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        seg_d     = seg_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    sh_d      = bin;
                    scr_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CW'(WIDTH);
                end
            end
            SHIFT: begin
                sh_d      = sh_q << 1;
                scr_d     = scr_shift;
                ovf_acc_d = ovf_acc_q | shout;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    bcd_d   = scr_shift;
                    ovf_d   = ovf_acc_q | shout;
                    seg_d   = seg_of(scr_shift, ovf_acc_q | shout);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            seg_q     <= seg_of('0, 1'b0);
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;
    assign bcd      = bcd_q;
    assign seg      = seg_q;
endmodule

// File: tb/tb_bcd_seq_display.sv
// Randomised and directed checks of bcd_seq_display against a decimal
// reference model, across several parameter sets.
module tb_bcd_seq_display;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic s8, s10, s16;
    logic [7:0]  b8;
    logic [9:0]  b10;
    logic [15:0] b16;

    logic        busy8, done8, ovf8, busy8n, done8n, ovf8n;
    logic [11:0] bcd8, bcd8n;
    logic [20:0] seg8, seg8n;
    logic        busy10, done10, ovf10;
    logic [11:0] bcd10;
    logic [20:0] seg10;
    logic        busy16, done16, ovf16;
    logic [19:0] bcd16;
    logic [34:0] seg16;

    int checks = 0;
    int errors = 0;

    bcd_seq_display #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(1)) u8 (
        .clk(clk), .reset(rst), .start(s8), .bin(b8), .busy(busy8), .done(done8),
        .overflow(ovf8), .bcd(bcd8), .seg(seg8));
    bcd_seq_display #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(0)) u8n (
        .clk(clk), .reset(rst), .start(s8), .bin(b8), .busy(busy8n), .done(done8n),
        .overflow(ovf8n), .bcd(bcd8n), .seg(seg8n));
    bcd_seq_display #(.WIDTH(10), .DIGITS(3), .BLANK_LEADING(1)) u10 (
        .clk(clk), .reset(rst), .start(s10), .bin(b10), .busy(busy10), .done(done10),
        .overflow(ovf10), .bcd(bcd10), .seg(seg10));
    bcd_seq_display #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(1)) u16 (
        .clk(clk), .reset(rst), .start(s16), .bin(b16), .busy(busy16), .done(done16),
        .overflow(ovf16), .bcd(bcd16), .seg(seg16));

    logic [6:0] SSD [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint p10(int n);
        longint r = 1;
        repeat (n) r = r * 10;
        return r;
    endfunction

    function automatic logic [63:0] ref_bcd(longint v, int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_seg(longint v, int d, bit blank);
        logic [63:0] r = '0;
        bit ov = (v >= p10(d));
        for (int i = 0; i < d; i++) begin
            if (ov)                           r[7*i +: 7] = 7'b0000110;
            else if (blank && i > 0 && v < p10(i)) r[7*i +: 7] = 7'b1111111;
            else                              r[7*i +: 7] = SSD[int'((v / p10(i)) % 10)];
        end
        return r;
    endfunction

    task automatic conv8(input logic [7:0] v, output int n, output logic dn);
        b8 = v; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        n = 0;
        while (!done8 && n < 30) begin tick(); n++; end
        dn = done8n;
        tick();
    endtask

    int n, nb, nd;
    logic dn;
    logic [11:0] got;
    logic [15:0] vals [1000];
    logic [7:0] v8;

    initial begin
        rst = 1'b1; s8 = 0; b8 = 0; s10 = 0; b10 = 0; s16 = 0; b16 = 0;
        repeat (3) tick();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst_bcd", bcd8, 0);
        chk("rst_seg", seg8, 21'b1111111_1111111_1000000);
        chk("rst_seg_nb", seg8n, 21'b1000000_1000000_1000000);
        chk("rst_seg16", seg16, ref_seg(0, 5, 1));
        rst = 1'b0;
        tick();

        // 255: latency and first result
        b8 = 8'd255; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        chk("busy_e0", busy8, 1);
        n = 0;
        while (!done8 && n < 30) begin tick(); n++; end
        chk("lat255", n, 8);
        chk("busy_at_done", busy8, 0);
        chk("bcd255", bcd8, 12'h255);
        chk("ovf255", ovf8, 0);
        chk("seg255", seg8, 21'b0100100_0010010_0010010);
        chk("seg255_nb", seg8n, 21'b0100100_0010010_0010010);
        tick();
        chk("done_pulse", done8, 0);

        conv8(8'd7, n, dn);
        chk("lat7", n, 8);
        chk("done7_nb", dn, 1);
        chk("bcd7", bcd8, 12'h007);
        chk("seg7", seg8, 21'b1111111_1111111_1111000);
        chk("seg7_nb", seg8n, 21'b1000000_1000000_1111000);

        conv8(8'd0, n, dn);
        chk("lat0", n, 8);
        chk("bcd0", bcd8, 0);
        chk("seg0", seg8, ref_seg(0, 3, 1));

        for (int k = 0; k < 20; k++) begin
            v8 = 8'($urandom_range(0, 255));
            conv8(v8, n, dn);
            chk("lat_r8", n, 8);
            chk("bcd_r8", bcd8, ref_bcd(v8, 3));
            chk("bcd_r8_nb", bcd8n, ref_bcd(v8, 3));
            chk("seg_r8", seg8, ref_seg(v8, 3, 1));
            chk("seg_r8_nb", seg8n, ref_seg(v8, 3, 0));
            chk("ovf_r8", ovf8 | ovf8n, 0);
        end

        // start during SHIFT must be ignored
        b8 = 8'd200; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        nb = 0; nd = 0; got = '0;
        for (int k = 0; k < 14; k++) begin
            if (busy8) nb++;
            if (done8) begin nd++; got = bcd8; end
            if (k == 2) begin s8 = 1'b1; b8 = 8'd50; end
            if (k == 3) s8 = 1'b0;
            tick();
        end
        chk("ign_busy", nb, 8);
        chk("ign_done", nd, 1);
        chk("ign_bcd", got, 12'h200);

        // reset mid-conversion
        b8 = 8'd255; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_bcd", bcd8, 0);
        chk("abort_ovf", ovf8, 0);
        chk("abort_seg", seg8, ref_seg(0, 3, 1));
        chk("abort_seg_nb", seg8n, ref_seg(0, 3, 0));
        rst = 1'b0;
        nd = 0;
        repeat (12) begin tick(); if (done8) nd++; end
        chk("abort_nodone", nd, 0);
        conv8(8'd100, n, dn);
        chk("bcd100", bcd8, 12'h100);
        chk("seg100", seg8, ref_seg(100, 3, 1));

        // overflow on 10-bit operand
        b10 = 10'd1000; s10 = 1'b1;
        tick();
        s10 = 1'b0;
        n = 0;
        while (!done10 && n < 30) begin tick(); n++; end
        chk("lat1000", n, 10);
        chk("ovf1000", ovf10, 1);
        chk("bcd1000", bcd10, 12'h000);
        chk("seg1000", seg10, 21'b0000110_0000110_0000110);
        tick();
        b10 = 10'd999; s10 = 1'b1;
        tick();
        s10 = 1'b0;
        n = 0;
        while (!done10 && n < 30) begin tick(); n++; end
        chk("ovf999", ovf10, 0);
        chk("bcd999", bcd10, 12'h999);
        chk("seg999", seg10, ref_seg(999, 3, 1));
        chk("busy10", busy10, 0);
        tick();

        // back-to-back random 16-bit conversions with start held high
        vals[0] = 16'd0;
        vals[1] = 16'hFFFF;
        for (int k = 2; k < 1000; k++) vals[k] = 16'($urandom_range(0, 65535));
        b16 = vals[0];
        s16 = 1'b1;
        for (int j = 0; j < 1000; j++) begin
            n = 0;
            do begin tick(); n++; end while (!done16 && n < 40);
            if (!done16) begin
                chk("timeout16", 0, 1);
                break;
            end
            if (j > 0) chk("gap16", n, 18);
            chk("bcd16", bcd16, ref_bcd(vals[j], 5));
            chk("seg16", seg16, ref_seg(vals[j], 5, 1));
            chk("ovf16", {busy16, ovf16}, 0);
            if (j + 1 < 1000) b16 = vals[j+1];
        end
        s16 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
